// File: rtl/camera_pix_pipe_if.sv
// Camera byte stream in, pixel / packed-word stream out; both sides valid/ready.
interface camera_pix_pipe_if;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_half;
    logic        out_valid;
    logic        out_ready;

    modport master (output in_data, in_sof, in_valid, out_ready,
                    input  in_ready, out_data, out_half, out_valid);
    modport slave  (input  in_data, in_sof, in_valid, out_ready,
                    output in_ready, out_data, out_half, out_valid);
endinterface

// File: rtl/camera_pix_pipe.sv
// Camera pixel pipeline: byte pairing, frame drop/slice, RGB->grey filter or
// 16-bit bypass, optional two-pixel packing; three stallable stages.
module camera_pix_pipe #(
    parameter int CNT_WIDTH   = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int FDROP_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   cfg_en_i,
    input  logic [2:0]             cfg_format_i,
    input  logic [3:0]             cfg_shift_i,
    input  logic [COEFF_WIDTH-1:0] cfg_r_coeff_i,
    input  logic [COEFF_WIDTH-1:0] cfg_g_coeff_i,
    input  logic [COEFF_WIDTH-1:0] cfg_b_coeff_i,
    input  logic                   cfg_framedrop_en_i,
    input  logic [FDROP_WIDTH-1:0] cfg_framedrop_val_i,
    input  logic                   cfg_slice_en_i,
    input  logic [CNT_WIDTH-1:0]   cfg_llx_i,
    input  logic [CNT_WIDTH-1:0]   cfg_lly_i,
    input  logic [CNT_WIDTH-1:0]   cfg_urx_i,
    input  logic [CNT_WIDTH-1:0]   cfg_ury_i,
    input  logic [CNT_WIDTH-1:0]   cfg_rowlen_i,
    input  logic                   cfg_pack_en_i,
    camera_pix_pipe_if.slave       pix,
    output logic [15:0]            frames_o
);
    localparam int SUM_W = 8 + COEFF_WIDTH + 2;
    localparam int EXT_W = (SUM_W > 17) ? SUM_W : 17;

    logic                   stall, xfer, pix_fire, kept_sof, in_win, fmt_ok, dbyp;
    logic                   r_active, r_keep, phase, b1_sof;
    logic [7:0]             b1, b2, dr, dg, db;
    logic [15:0]            dpass, res;
    logic [FDROP_WIDTH-1:0] fcnt;
    logic [CNT_WIDTH-1:0]   col, row;
    logic [1:0]             vld_pipe;
    logic [7:0]             s1_r, s1_g, s1_b;
    logic [15:0]            s1_pass, s2_pass, pend;
    logic                   s1_byp, s1_sof, s2_byp, s2_sof, pend_vld;
    logic [SUM_W-1:0]       sum_c, s2_sum;
    logic [EXT_W-1:0]       shifted;

    assign b2           = pix.in_data;
    assign stall        = pix.out_valid & ~pix.out_ready;
    assign pix.in_ready = ~stall;
    assign xfer         = pix.in_valid & ~stall;
    assign pix_fire     = xfer & ~pix.in_sof & r_active & phase & cfg_en_i;
    assign kept_sof     = (fcnt == '0) | ~cfg_framedrop_en_i;
    assign in_win       = (col >= cfg_llx_i) && (col <= cfg_urx_i) &&
                          (row >= cfg_lly_i) && (row <= cfg_ury_i);

    always_comb begin
        dr     = '0;
        dg     = '0;
        db     = '0;
        dbyp   = 1'b0;
        fmt_ok = 1'b1;
        dpass  = {b1, b2};
        case (cfg_format_i)
            3'b000: begin
                dr = {b1[7:3], 3'b0};
                dg = {b1[2:0], b2[7:5], 2'b0};
                db = {b2[4:0], 3'b0};
            end
            3'b001: begin
                dr = {b1[6:2], 3'b0};
                dg = {b1[1:0], b2[7:5], 3'b0};
                db = {b2[4:0], 3'b0};
            end
            3'b010: begin
                dr = {b1[3:0], 4'b0};
                dg = {b2[7:4], 4'b0};
                db = {b2[3:0], 4'b0};
            end
            3'b100: dbyp = 1'b1;
            3'b101: begin
                dbyp  = 1'b1;
                dpass = {b2, b1};
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    // Sum is wide enough for three full-scale products, so no overflow.
    assign sum_c = SUM_W'(s1_r) * SUM_W'(cfg_r_coeff_i)
                 + SUM_W'(s1_g) * SUM_W'(cfg_g_coeff_i)
                 + SUM_W'(s1_b) * SUM_W'(cfg_b_coeff_i);
    assign shifted = EXT_W'(s2_sum) >> cfg_shift_i;
    assign res     = s2_byp ? s2_pass : ((|shifted[EXT_W-1:16]) ? 16'hFFFF : shifted[15:0]);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_active      <= 1'b0;
            r_keep        <= 1'b0;
            phase         <= 1'b0;
            b1            <= '0;
            b1_sof        <= 1'b0;
            fcnt          <= '0;
            col           <= '0;
            row           <= '0;
            frames_o      <= '0;
            vld_pipe      <= '0;
            s1_r          <= '0;
            s1_g          <= '0;
            s1_b          <= '0;
            s1_pass       <= '0;
            s1_byp        <= 1'b0;
            s1_sof        <= 1'b0;
            s2_sum        <= '0;
            s2_pass       <= '0;
            s2_byp        <= 1'b0;
            s2_sof        <= 1'b0;
            pend          <= '0;
            pend_vld      <= 1'b0;
            pix.out_data  <= '0;
            pix.out_half  <= 1'b0;
            pix.out_valid <= 1'b0;
        end else begin
            if (xfer) begin
                if (pix.in_sof) begin
                    r_active <= cfg_en_i;
                    phase    <= cfg_en_i;
                    b1       <= b2;
                    b1_sof   <= 1'b1;
                    col      <= '0;
                    row      <= '0;
                    if (cfg_en_i) begin
                        r_keep <= kept_sof;
                        fcnt   <= (!cfg_framedrop_en_i || fcnt == cfg_framedrop_val_i)
                                  ? '0 : fcnt + FDROP_WIDTH'(1);
                        if (kept_sof) frames_o <= frames_o + 16'd1;
                    end
                end else if (r_active) begin
                    phase <= ~phase;
                    if (!phase) begin
                        b1     <= b2;
                        b1_sof <= 1'b0;
                    end else begin
                        col <= (col == cfg_rowlen_i) ? '0 : col + CNT_WIDTH'(1);
                        if (col == cfg_rowlen_i && row != '1) row <= row + CNT_WIDTH'(1);
                    end
                end
            end
            if (!stall) begin
                vld_pipe[0] <= pix_fire & r_keep & fmt_ok & (~cfg_slice_en_i | in_win);
                s1_r        <= dr;
                s1_g        <= dg;
                s1_b        <= db;
                s1_pass     <= dpass;
                s1_byp      <= dbyp;
                s1_sof      <= b1_sof;
                vld_pipe[1] <= vld_pipe[0];
                s2_sum      <= sum_c;
                s2_pass     <= s1_pass;
                s2_byp      <= s1_byp;
                s2_sof      <= s1_sof;
                // While disabled the output register only drains.
                if (vld_pipe[1] && cfg_en_i) begin
                    if (!cfg_pack_en_i) begin
                        pix.out_data  <= {16'h0, res};
                        pix.out_half  <= 1'b1;
                        pix.out_valid <= 1'b1;
                    end else if (pend_vld && s2_sof) begin
                        pix.out_data  <= {16'h0, pend};
                        pix.out_half  <= 1'b1;
                        pix.out_valid <= 1'b1;
                        pend          <= res;
                    end else if (pend_vld) begin
                        pix.out_data  <= {res, pend};
                        pix.out_half  <= 1'b0;
                        pix.out_valid <= 1'b1;
                        pend_vld      <= 1'b0;
                    end else begin
                        pend          <= res;
                        pend_vld      <= 1'b1;
                        pix.out_valid <= 1'b0;
                    end
                end else begin
                    pix.out_valid <= 1'b0;
                end
            end
            if (!cfg_en_i) begin
                r_active <= 1'b0;
                phase    <= 1'b0;
                vld_pipe <= '0;
                pend_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_camera_pix_pipe.sv
// Bench for camera_pix_pipe: format/filter vector table plus scoreboarded
// sequences for packing, frame drop, slicing, stall, enable and reset.
module tb_camera_pix_pipe;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_en, cfg_fd_en, cfg_slice_en, cfg_pack_en;
    logic [2:0]  cfg_fmt;
    logic [3:0]  cfg_sh;
    logic [7:0]  cfg_cr, cfg_cg, cfg_cb;
    logic [5:0]  cfg_fd_val;
    logic [15:0] cfg_llx, cfg_lly, cfg_urx, cfg_ury, cfg_rowlen;
    logic [15:0] frames;

    always #5 clk = ~clk;

    camera_pix_pipe_if pif();

    camera_pix_pipe dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_format_i(cfg_fmt),
        .cfg_shift_i(cfg_sh), .cfg_r_coeff_i(cfg_cr), .cfg_g_coeff_i(cfg_cg),
        .cfg_b_coeff_i(cfg_cb), .cfg_framedrop_en_i(cfg_fd_en),
        .cfg_framedrop_val_i(cfg_fd_val), .cfg_slice_en_i(cfg_slice_en),
        .cfg_llx_i(cfg_llx), .cfg_lly_i(cfg_lly), .cfg_urx_i(cfg_urx),
        .cfg_ury_i(cfg_ury), .cfg_rowlen_i(cfg_rowlen), .cfg_pack_en_i(cfg_pack_en),
        .pix(pif), .frames_o(frames)
    );

    typedef struct { logic [31:0] data; logic half; int cyc; } exp_t;
    typedef struct {
        logic [2:0] fmt; logic [7:0] cr, cg, cb; logic [3:0] sh;
        logic [7:0] b1, b2; logic has; logic [15:0] res;
    } vec_t;

    exp_t q[$];
    vec_t vt[12];
    int   checks = 0, failures = 0, ncyc = 0, last_xfer = 0, sg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [31:0] d, input logic h, input int c);
        exp_t e;
        e.data = d; e.half = h; e.cyc = c;
        q.push_back(e);
    endfunction

    // Output monitor: compares every accepted word against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (rstn && pif.out_valid && pif.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %h half=%0d, expected no word", pif.out_data, pif.out_half);
            end else begin
                e = q.pop_front();
                chk("out_data", pif.out_data, e.data);
                chk("out_half", 32'(pif.out_half), 32'(e.half));
                if (e.cyc >= 0) chk("out_latency", 32'(ncyc), 32'(e.cyc));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s);
        int g;
        g = 0;
        @(negedge clk); #1;
        pif.in_data = d; pif.in_sof = s; pif.in_valid = 1'b1;
        while (!pif.in_ready && g < 200) begin @(negedge clk); #1; g++; end
        if (g >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck at %0d, expected 1", pif.in_ready);
        end
        last_xfer = ncyc;
        @(posedge clk); #1;
        pif.in_valid = 1'b0; pif.in_sof = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (q.size() != 0 && g < 300) begin @(negedge clk); g++; end
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1;
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; cfg_en = 1'b1; cfg_fmt = 3'b000; cfg_sh = 4'd8;
        cfg_cr = 8'd77; cfg_cg = 8'd150; cfg_cb = 8'd29;
        cfg_fd_en = 1'b0; cfg_fd_val = '0; cfg_slice_en = 1'b0; cfg_pack_en = 1'b0;
        cfg_llx = '0; cfg_lly = '0; cfg_urx = '0; cfg_ury = '0; cfg_rowlen = 16'hFFFF;
        pif.in_data = '0; pif.in_sof = 1'b0; pif.in_valid = 1'b0; pif.out_ready = 1'b1;

        vt[0]  = '{3'b000, 8'd77, 8'd150, 8'd29, 4'd8,  8'hF8, 8'h00, 1'b1, 16'h004A};
        vt[1]  = '{3'b000, 8'd77, 8'd150, 8'd29, 4'd8,  8'h07, 8'hE0, 1'b1, 16'h0093};
        vt[2]  = '{3'b000, 8'd77, 8'd150, 8'd29, 4'd8,  8'h00, 8'h1F, 1'b1, 16'h001C};
        vt[3]  = '{3'b001, 8'd77, 8'd150, 8'd29, 4'd0,  8'h7C, 8'h00, 1'b1, 16'h4A98};
        vt[4]  = '{3'b001, 8'd77, 8'd150, 8'd29, 4'd4,  8'h03, 8'hE0, 1'b1, 16'h0915};
        vt[5]  = '{3'b010, 8'd3,  8'd5,   8'd7,  4'd1,  8'h0F, 8'hA5, 1'b1, 16'h0410};
        vt[6]  = '{3'b100, 8'd0,  8'd0,   8'd0,  4'd0,  8'h12, 8'h34, 1'b1, 16'h1234};
        vt[7]  = '{3'b101, 8'd0,  8'd0,   8'd0,  4'd0,  8'h12, 8'h34, 1'b1, 16'h3412};
        vt[8]  = '{3'b000, 8'hFF, 8'hFF,  8'hFF, 4'd0,  8'hFF, 8'hFF, 1'b1, 16'hFFFF};
        vt[9]  = '{3'b000, 8'hFF, 8'hFF,  8'hFF, 4'd2,  8'hFF, 8'hFF, 1'b1, 16'hBA45};
        vt[10] = '{3'b000, 8'hFF, 8'hFF,  8'hFF, 4'd15, 8'hFF, 8'hFF, 1'b1, 16'h0005};
        vt[11] = '{3'b011, 8'd1,  8'd1,   8'd1,  4'd0,  8'h12, 8'h34, 1'b0, 16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(pif.out_valid), 32'd0);
        chk("rst_out_data",  pif.out_data, 32'd0);
        chk("rst_out_half",  32'(pif.out_half), 32'd0);
        chk("rst_in_ready",  32'(pif.in_ready), 32'd1);
        chk("rst_frames",    32'(frames), 32'd0);
        @(posedge clk); #1; rstn = 1'b1;

        // Two 565 pixels in one frame, each checked for N+3 latency.
        send(8'hF8, 1'b1); send(8'h00, 1'b0); push(32'h0000004A, 1'b1, last_xfer + 3);
        send(8'h07, 1'b0); send(8'hE0, 1'b0); push(32'h00000093, 1'b1, last_xfer + 3);
        drain("lat_drain");

        for (int i = 0; i < 12; i++) begin
            cfg_fmt = vt[i].fmt; cfg_cr = vt[i].cr; cfg_cg = vt[i].cg;
            cfg_cb = vt[i].cb; cfg_sh = vt[i].sh;
            send(vt[i].b1, 1'b1); send(vt[i].b2, 1'b0);
            if (vt[i].has) push({16'h0, vt[i].res}, 1'b1, last_xfer + 3);
            drain("vec_drain");
        end

        // Packing, big-endian bypass; pending half flushed only by the next sof.
        cfg_fmt = 3'b101; cfg_pack_en = 1'b1;
        send(8'h12, 1'b1); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b0);
        push(32'h78563412, 1'b0, last_xfer + 3);
        drain("pack_drain");
        send(8'hAB, 1'b1); send(8'hCD, 1'b0);
        repeat (10) @(negedge clk);
        chk("pend_hold", 32'(pif.out_valid), 32'd0);
        send(8'hEF, 1'b1); send(8'h01, 1'b0);
        push(32'h0000CDAB, 1'b1, last_xfer + 3);
        drain("flush_drain");
        cfg_en = 1'b0; repeat (2) @(negedge clk); cfg_en = 1'b1; cfg_pack_en = 1'b0;

        // Saturated 565 pixels with the output stalled for 10 cycles.
        cfg_fmt = 3'b000; cfg_cr = 8'hFF; cfg_cg = 8'hFF; cfg_cb = 8'hFF; cfg_sh = 4'd0;
        @(posedge clk); #1; pif.out_ready = 1'b0;
        fork
            begin
                send(8'hFF, 1'b1); send(8'hFF, 1'b0); push(32'h0000FFFF, 1'b1, -1);
                send(8'hF8, 1'b0); send(8'h00, 1'b0); push(32'h0000F708, 1'b1, -1);
                send(8'h07, 1'b0); send(8'hE0, 1'b0); push(32'h0000FB04, 1'b1, -1);
            end
            begin
                sg = 0;
                while (!pif.out_valid && sg < 50) begin @(negedge clk); sg++; end
                chk("stall_valid0", 32'(pif.out_valid), 32'd1);
                chk("stall_data0",  pif.out_data, 32'h0000FFFF);
                repeat (10) @(negedge clk);
                chk("stall_in_ready", 32'(pif.in_ready), 32'd0);
                chk("stall_valid10",  32'(pif.out_valid), 32'd1);
                chk("stall_data10",   pif.out_data, 32'h0000FFFF);
                chk("stall_half10",   32'(pif.out_half), 32'd1);
                @(posedge clk); #1; pif.out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Enable dropped mid-frame, raised mid-frame, then resumed at sof.
        cfg_fmt = 3'b100;
        send(8'h11, 1'b1); send(8'h22, 1'b0); push(32'h00001122, 1'b1, -1);
        send(8'h33, 1'b0); send(8'h44, 1'b0);
        cfg_en = 1'b0;
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        repeat (3) @(negedge clk);
        cfg_en = 1'b1;
        send(8'h77, 1'b0); send(8'h88, 1'b0); send(8'h99, 1'b0); send(8'hAA, 1'b0);
        repeat (5) @(negedge clk);
        send(8'hBB, 1'b1); send(8'hCC, 1'b0); push(32'h0000BBCC, 1'b1, -1);
        drain("en_drain");

        // 4x4 frame through a (1,1)-(2,2) slice; pixel data is {row,col}.
        cfg_rowlen = 16'd3; cfg_slice_en = 1'b1;
        cfg_llx = 16'd1; cfg_lly = 16'd1; cfg_urx = 16'd2; cfg_ury = 16'd2;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                send(8'(r), (r == 0 && c == 0));
                send(8'(c), 1'b0);
                if (r >= 1 && r <= 2 && c >= 1 && c <= 2) push({16'h0, 8'(r), 8'(c)}, 1'b1, -1);
            end
        drain("slice_drain");
        cfg_slice_en = 1'b0; cfg_rowlen = 16'hFFFF;

        // Keep 1 frame in 3 over 6 frames; pixel data is {frame,pixel}.
        do_reset();
        cfg_fd_en = 1'b1; cfg_fd_val = 6'd2;
        for (int f = 0; f < 6; f++)
            for (int p = 0; p < 4; p++) begin
                send(8'(f), (p == 0));
                send(8'(p), 1'b0);
                if (f == 0 || f == 3) push({16'h0, 8'(f), 8'(p)}, 1'b1, -1);
            end
        drain("fdrop_drain");
        chk("fdrop_frames", 32'(frames), 32'd2);
        cfg_fd_en = 1'b0;

        // Reset with a stalled word in the output register.
        @(posedge clk); #1; pif.out_ready = 1'b0;
        send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        chk("pre_rst_valid", 32'(pif.out_valid), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid",    32'(pif.out_valid), 32'd0);
        chk("mid_rst_data",     pif.out_data, 32'd0);
        chk("mid_rst_half",     32'(pif.out_half), 32'd0);
        chk("mid_rst_in_ready", 32'(pif.in_ready), 32'd1);
        chk("mid_rst_frames",   32'(frames), 32'd0);
        rstn = 1'b1; pif.out_ready = 1'b1;
        send(8'h05, 1'b0); send(8'h06, 1'b0);
        repeat (5) @(negedge clk);
        send(8'h0A, 1'b1); send(8'h0B, 1'b0); push(32'h00000A0B, 1'b1, last_xfer + 3);
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
